mem_addr_unit: RTL and testbench
================================

MEM_ADDR_UNIT -- requirements
Module: mem_addr_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter width.
REQ-002 SHALL have parameter BUS_W, default 8, data-bus width and MAR lane width.
REQ-003 SHALL have parameter MAR_W, default 16, MAR and immediate width, a multiple of BUS_W.
REQ-004 SHALL have parameter SP_W, default BUS_W, stack-pointer width.
REQ-005 SHALL have parameters STACK_PAGE, default 8'hFF, and IO_PAGE, default 8'hFE, the page selects (top BUS_W address bits).
REQ-006 SHALL have parameter BP_COUNT, default 4, number of breakpoint slots (>=1).
REQ-007 Ports: i_clk  in  1  clock; i_reset  in  1  reset, asynchronous, active-high.
REQ-008 i_bus  in  BUS_W  data bus; i_halt  in  1  freezes PC increment and SP.
REQ-009 i_pcLoadN  in  1  PC load, active low; i_pcNEn  in  1  PC increment, active low; i_pcFromImm  in  1  load source (1 imm, 0 MAR).
REQ-010 i_spNEn  in  1  SP step, active low; i_spUp  in  1  direction; i_spClrFlags  in  1  clear SP flags.
REQ-011 i_marNWE  in  MAR_W/BUS_W  per-lane MAR write, active low; i_immToAddr  in  1  address source (1 imm, 0 MAR).
REQ-012 i_instrNWE  in  1  IR write, active low; i_romData  in  8+MAR_W  {opcode, immediate}.
REQ-013 i_bpWrite  in  1  slot write; i_bpIndex  in  clog2(BP_COUNT)  slot; i_bpAddr  in  PC_W  address; i_bpEnable  in  1  slot enable; i_bpAck  in  1  clear latched hit.
REQ-014 o_romAddress  out  PC_W  = PC; o_pc  out  PC_W  debug PC; o_sp  out  SP_W  SP.
REQ-015 o_instrCode  out  8  opcode; o_instrImm  out  MAR_W  immediate.
REQ-016 o_ramAddress  out  MAR_W+1  RAM address, MSB = not-stack; o_ioNCE  out  1  IO select, active low.
REQ-017 o_spOverflow, o_spUnderflow  out  1  sticky SP flags; o_bpHitN  out  1  live hit, active low; o_bpHitIdx  out  clog2(BP_COUNT)  lowest hit slot; o_bpLatched  out  1  sticky hit / halt request.

Function
REQ-018 PC: !i_pcLoadN loads imm[PC_W-1:0] (i_pcFromImm=1) or MAR[PC_W-1:0] (0), regardless of i_halt; else !i_pcNEn && !i_halt increments modulo 2^PC_W.
REQ-019 SP: step when !i_spNEn && !i_halt; up at all-ones or down at zero SHALL hold SP and set the respective sticky flag, no wrap.
REQ-020 i_spClrFlags clears both flags next edge; simultaneous new violation: set wins.
REQ-021 MAR: each low i_marNWE[k] loads lane k from i_bus; any lane combination in one cycle.
REQ-022 IR: !i_instrNWE latches opcode and immediate from i_romData, one-cycle latency.
REQ-023 Address (combinational): base = i_immToAddr ? imm : MAR; page = base top BUS_W bits.
REQ-024 page==STACK_PAGE: o_ramAddress = {0, SP, base low MAR_W-SP_W bits}; else {1, base}.
REQ-025 o_ioNCE = (page != IO_PAGE); stack and IO pages never both selected.
REQ-026 Breakpoints: i_bpWrite writes slot i_bpIndex {i_bpAddr, i_bpEnable}; hit = enabled slot address == current PC.
REQ-027 o_bpHitN low combinationally on any hit; o_bpHitIdx = lowest hitting index, 0 if none.
REQ-028 o_bpLatched sets on rising edge of any-hit (registered previous-hit), clears on i_bpAck; ack and new rising hit same cycle: set wins.
REQ-029 Slot write to the currently-hit slot takes effect next cycle; no glitch-latch from the old value.

Reset
REQ-030 i_reset clears PC, SP, MAR, IR, all slots (disabled), flags, previous-hit register, o_bpLatched; asserts mid-operation immediately.
REQ-031 After reset: o_romAddress=0, o_ramAddress={1,0}, o_ioNCE=1, o_bpHitN=1, o_bpHitIdx=0.

Structure
REQ-032 Package mem_addr_pkg SHALL hold parameter defaults, STACK_PAGE/IO_PAGE constants and a lane-count function.
REQ-033 Sub-module bp_slot (one register plus comparator) SHALL be instantiated BP_COUNT times.

Verification
REQ-034 Reset, PC=16'h00FF, !i_pcNEn three cycles with i_halt high on second -> PC 0x0100, 0x0100, 0x0101.
REQ-035 SP=0xFE, step up three times -> SP 0xFF, 0xFF, o_spOverflow=1; clear plus down step same cycle -> flag 0, SP 0xFE.
REQ-036 MAR lanes 0x34/0x12 then i_immToAddr=0 -> o_ramAddress=17'h11234; MAR=0xFF10, SP=0x05 -> 17'h00510; MAR=0xFE22 -> o_ioNCE=0.
REQ-037 Slot2=0x0040 enabled, PC counts to 0x40 -> o_bpHitN=0, idx=2, o_bpLatched next edge; i_bpAck -> clears, no re-set while PC holds 0x40.
REQ-038 IR imm=0x1234, !i_pcLoadN, i_pcFromImm=1, i_halt=1 -> PC=0x1234 next edge.

Source files
------------

// File: rtl/mem_addr_pkg.sv
// Shared defaults and helpers for the memory address unit: widths, page selects,
// and derived lane/index widths.
package mem_addr_pkg;

    localparam int PC_W_DEF     = 16;
    localparam int BUS_W_DEF    = 8;
    localparam int MAR_W_DEF    = 16;
    localparam int BP_COUNT_DEF = 4;

    localparam logic [7:0] STACK_PAGE_DEF = 8'hFF;
    localparam logic [7:0] IO_PAGE_DEF    = 8'hFE;

    function automatic int lane_count(input int mar_w, input int bus_w);
        return mar_w / bus_w;
    endfunction

    // Index width that stays at least one bit for a single-slot configuration.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/bp_slot.sv
// One breakpoint slot: an address/enable register and an equality comparator
// against the current program counter.
module bp_slot
    import mem_addr_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_we,
    input  logic [PC_W-1:0] i_addr,
    input  logic            i_en,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_hit
);

    logic [PC_W-1:0] addr_q;
    logic            en_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            addr_q <= '0;
            en_q   <= 1'b0;
        end else if (i_we) begin
            addr_q <= i_addr;
            en_q   <= i_en;
        end
    end

    assign o_hit = en_q && (addr_q == i_pc);

endmodule

// File: rtl/mem_addr_unit.sv
// Memory address unit: PC, saturating SP, lane-written MAR, instruction register,
// stack/IO page decode and a bank of PC breakpoints with a sticky hit latch.
module mem_addr_unit
    import mem_addr_pkg::*;
#(
    parameter int                 PC_W       = PC_W_DEF,
    parameter int                 BUS_W      = BUS_W_DEF,
    parameter int                 MAR_W      = MAR_W_DEF,
    parameter int                 SP_W       = BUS_W,
    parameter logic [BUS_W-1:0]   STACK_PAGE = STACK_PAGE_DEF,
    parameter logic [BUS_W-1:0]   IO_PAGE    = IO_PAGE_DEF,
    parameter int                 BP_COUNT   = BP_COUNT_DEF
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic [BUS_W-1:0]                      i_bus,
    input  logic                                  i_halt,
    input  logic                                  i_pcLoadN,
    input  logic                                  i_pcNEn,
    input  logic                                  i_pcFromImm,
    input  logic                                  i_spNEn,
    input  logic                                  i_spUp,
    input  logic                                  i_spClrFlags,
    input  logic [lane_count(MAR_W, BUS_W)-1:0]   i_marNWE,
    input  logic                                  i_immToAddr,
    input  logic                                  i_instrNWE,
    input  logic [8+MAR_W-1:0]                    i_romData,
    input  logic                                  i_bpWrite,
    input  logic [idx_width(BP_COUNT)-1:0]        i_bpIndex,
    input  logic [PC_W-1:0]                       i_bpAddr,
    input  logic                                  i_bpEnable,
    input  logic                                  i_bpAck,
    output logic [PC_W-1:0]                       o_romAddress,
    output logic [PC_W-1:0]                       o_pc,
    output logic [SP_W-1:0]                       o_sp,
    output logic [7:0]                            o_instrCode,
    output logic [MAR_W-1:0]                      o_instrImm,
    output logic [MAR_W:0]                        o_ramAddress,
    output logic                                  o_ioNCE,
    output logic                                  o_spOverflow,
    output logic                                  o_spUnderflow,
    output logic                                  o_bpHitN,
    output logic [idx_width(BP_COUNT)-1:0]        o_bpHitIdx,
    output logic                                  o_bpLatched
);

    localparam int LANES    = lane_count(MAR_W, BUS_W);
    localparam int BP_IDX_W = idx_width(BP_COUNT);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [MAR_W-1:0] mar_q, mar_d;
    logic [7:0]       op_q, op_d;
    logic [MAR_W-1:0] imm_q, imm_d;
    logic             ovf_q, ovf_d, und_q, und_d;
    logic             prev_hit_q, latched_q, latched_d;
    logic             ovf_set, und_set;

    logic [BP_COUNT-1:0] bp_hits;
    logic                any_hit;
    logic [BP_IDX_W-1:0] hit_idx;
    logic [MAR_W-1:0]    base;
    logic [BUS_W-1:0]    page;

    for (genvar g = 0; g < BP_COUNT; g++) begin : g_slot
        bp_slot #(.PC_W(PC_W)) u_slot (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_we    (i_bpWrite && (i_bpIndex == BP_IDX_W'(g))),
            .i_addr  (i_bpAddr),
            .i_en    (i_bpEnable),
            .i_pc    (pc_q),
            .o_hit   (bp_hits[g])
        );
    end

    assign any_hit = |bp_hits;

    // Scan from the top so the lowest hitting slot is the last one written.
    always_comb begin
        hit_idx = '0;
        for (int k = BP_COUNT - 1; k >= 0; k--) begin
            if (bp_hits[k]) hit_idx = BP_IDX_W'(k);
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        mar_d   = mar_q;
        op_d    = op_q;
        imm_d   = imm_q;
        ovf_set = 1'b0;
        und_set = 1'b0;

        if (!i_pcLoadN) begin
            pc_d = i_pcFromImm ? imm_q[PC_W-1:0] : mar_q[PC_W-1:0];
        end else if (!i_pcNEn && !i_halt) begin
            pc_d = pc_q + 1'b1;
        end

        // The stack pointer saturates; an out-of-range step only raises a flag.
        if (!i_spNEn && !i_halt) begin
            if (i_spUp) begin
                if (&sp_q) ovf_set = 1'b1;
                else       sp_d    = sp_q + 1'b1;
            end else begin
                if (sp_q == '0) und_set = 1'b1;
                else            sp_d    = sp_q - 1'b1;
            end
        end

        for (int k = 0; k < LANES; k++) begin
            if (!i_marNWE[k]) mar_d[k*BUS_W +: BUS_W] = i_bus;
        end

        if (!i_instrNWE) begin
            op_d  = i_romData[MAR_W +: 8];
            imm_d = i_romData[MAR_W-1:0];
        end

        ovf_d     = (ovf_q && !i_spClrFlags) || ovf_set;
        und_d     = (und_q && !i_spClrFlags) || und_set;
        latched_d = (any_hit && !prev_hit_q) || (latched_q && !i_bpAck);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_q       <= '0;
            sp_q       <= '0;
            mar_q      <= '0;
            op_q       <= '0;
            imm_q      <= '0;
            ovf_q      <= 1'b0;
            und_q      <= 1'b0;
            prev_hit_q <= 1'b0;
            latched_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            mar_q      <= mar_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            ovf_q      <= ovf_d;
            und_q      <= und_d;
            prev_hit_q <= any_hit;
            latched_q  <= latched_d;
        end
    end

    assign base = i_immToAddr ? imm_q : mar_q;
    assign page = base[MAR_W-1 -: BUS_W];

    // Stack page swaps the page byte for the SP; MSB flags a non-stack access.
    always_comb begin
        if (page == STACK_PAGE) o_ramAddress = {1'b0, sp_q, base[MAR_W-SP_W-1:0]};
        else                    o_ramAddress = {1'b1, base};
    end

    assign o_ioNCE       = !((page == IO_PAGE) && (page != STACK_PAGE));
    assign o_romAddress  = pc_q;
    assign o_pc          = pc_q;
    assign o_sp          = sp_q;
    assign o_instrCode   = op_q;
    assign o_instrImm    = imm_q;
    assign o_spOverflow  = ovf_q;
    assign o_spUnderflow = und_q;
    assign o_bpHitN      = !any_hit;
    assign o_bpHitIdx    = hit_idx;
    assign o_bpLatched   = latched_q;

endmodule

// File: tb/tb_mem_addr_unit.sv
// Directed bench for mem_addr_unit: an arithmetic reference model checked every
// cycle, plus hand-computed literal checkpoints.
module tb_mem_addr_unit;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_bus = '0;
    logic        i_halt = 1'b0;
    logic        i_pcLoadN = 1'b1, i_pcNEn = 1'b1, i_pcFromImm = 1'b0;
    logic        i_spNEn = 1'b1, i_spUp = 1'b0, i_spClrFlags = 1'b0;
    logic [1:0]  i_marNWE = 2'b11;
    logic        i_immToAddr = 1'b0;
    logic        i_instrNWE = 1'b1;
    logic [23:0] i_romData = '0;
    logic        i_bpWrite = 1'b0;
    logic [1:0]  i_bpIndex = '0;
    logic [15:0] i_bpAddr = '0;
    logic        i_bpEnable = 1'b0, i_bpAck = 1'b0;

    logic [15:0] o_romAddress, o_pc;
    logic [7:0]  o_sp, o_instrCode;
    logic [15:0] o_instrImm;
    logic [16:0] o_ramAddress;
    logic        o_ioNCE, o_spOverflow, o_spUnderflow, o_bpHitN, o_bpLatched;
    logic [1:0]  o_bpHitIdx;

    mem_addr_unit dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_bus(i_bus), .i_halt(i_halt),
        .i_pcLoadN(i_pcLoadN), .i_pcNEn(i_pcNEn), .i_pcFromImm(i_pcFromImm),
        .i_spNEn(i_spNEn), .i_spUp(i_spUp), .i_spClrFlags(i_spClrFlags),
        .i_marNWE(i_marNWE), .i_immToAddr(i_immToAddr), .i_instrNWE(i_instrNWE),
        .i_romData(i_romData), .i_bpWrite(i_bpWrite), .i_bpIndex(i_bpIndex),
        .i_bpAddr(i_bpAddr), .i_bpEnable(i_bpEnable), .i_bpAck(i_bpAck),
        .o_romAddress(o_romAddress), .o_pc(o_pc), .o_sp(o_sp),
        .o_instrCode(o_instrCode), .o_instrImm(o_instrImm),
        .o_ramAddress(o_ramAddress), .o_ioNCE(o_ioNCE),
        .o_spOverflow(o_spOverflow), .o_spUnderflow(o_spUnderflow),
        .o_bpHitN(o_bpHitN), .o_bpHitIdx(o_bpHitIdx), .o_bpLatched(o_bpLatched)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, kept as plain integers.
    int m_pc, m_sp, m_mar, m_op, m_imm;
    bit m_ovf, m_und, m_prev, m_lat;
    int m_slot_addr [4];
    bit m_slot_en   [4];

    function automatic int model_hit_idx();
        for (int s = 0; s < 4; s++)
            if (m_slot_en[s] && m_slot_addr[s] == m_pc) return s;
        return -1;
    endfunction

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_pc = 0; m_sp = 0; m_mar = 0; m_op = 0; m_imm = 0;
            m_ovf = 0; m_und = 0; m_prev = 0; m_lat = 0;
            for (int s = 0; s < 4; s++) begin m_slot_addr[s] = 0; m_slot_en[s] = 0; end
        end else begin
            bit hit_now, ovf_new, und_new;
            hit_now = (model_hit_idx() >= 0);
            m_lat   = (hit_now && !m_prev) ? 1'b1 : (i_bpAck ? 1'b0 : m_lat);
            m_prev  = hit_now;

            if (!i_pcLoadN)               m_pc = (i_pcFromImm ? m_imm : m_mar) % 65536;
            else if (!i_pcNEn && !i_halt) m_pc = (m_pc + 1) % 65536;

            ovf_new = 0; und_new = 0;
            if (!i_spNEn && !i_halt) begin
                if (i_spUp) begin
                    if (m_sp == 255) ovf_new = 1; else m_sp = m_sp + 1;
                end else begin
                    if (m_sp == 0) und_new = 1; else m_sp = m_sp - 1;
                end
            end
            if (i_spClrFlags) begin m_ovf = 0; m_und = 0; end
            if (ovf_new) m_ovf = 1;
            if (und_new) m_und = 1;

            if (!i_marNWE[0]) m_mar = (m_mar / 256) * 256 + int'(i_bus);
            if (!i_marNWE[1]) m_mar = (m_mar % 256) + int'(i_bus) * 256;

            if (!i_instrNWE) begin
                m_op  = int'(i_romData) / 65536;
                m_imm = int'(i_romData) % 65536;
            end

            if (i_bpWrite) begin
                m_slot_addr[i_bpIndex] = int'(i_bpAddr);
                m_slot_en[i_bpIndex]   = i_bpEnable;
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_en && !i_reset) begin
            int base, page, exp_ram, idx;
            base    = i_immToAddr ? m_imm : m_mar;
            page    = base / 256;
            exp_ram = (page == 255) ? m_sp * 256 + base % 256 : 65536 + base;
            idx     = model_hit_idx();
            check("romAddress", 32'(o_romAddress), 32'(m_pc));
            check("pc", 32'(o_pc), 32'(m_pc));
            check("sp", 32'(o_sp), 32'(m_sp));
            check("instrCode", 32'(o_instrCode), 32'(m_op));
            check("instrImm", 32'(o_instrImm), 32'(m_imm));
            check("ramAddress", 32'(o_ramAddress), 32'(exp_ram));
            check("ioNCE", 32'(o_ioNCE), (page == 254) ? 32'd0 : 32'd1);
            check("spOverflow", 32'(o_spOverflow), 32'(m_ovf));
            check("spUnderflow", 32'(o_spUnderflow), 32'(m_und));
            check("bpHitN", 32'(o_bpHitN), (idx >= 0) ? 32'd0 : 32'd1);
            check("bpHitIdx", 32'(o_bpHitIdx), (idx >= 0) ? 32'(idx) : 32'd0);
            check("bpLatched", 32'(o_bpLatched), 32'(m_lat));
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic mar_write(input logic [1:0] lanes_n, input logic [7:0] val);
        i_marNWE = lanes_n; i_bus = val;
        tick();
        i_marNWE = 2'b11;
    endtask

    task automatic bp_write(input int idx, input logic [15:0] addr, input logic en);
        i_bpWrite = 1'b1; i_bpIndex = 2'(idx); i_bpAddr = addr; i_bpEnable = en;
        tick();
        i_bpWrite = 1'b0;
    endtask

    initial begin
        tick(); tick();
        check("rst romAddress", 32'(o_romAddress), 32'h0);
        check("rst ramAddress", 32'(o_ramAddress), 32'h10000);
        check("rst ioNCE", 32'(o_ioNCE), 32'h1);
        check("rst bpHitN", 32'(o_bpHitN), 32'h1);
        check("rst bpHitIdx", 32'(o_bpHitIdx), 32'h0);
        check("rst bpLatched", 32'(o_bpLatched), 32'h0);
        i_reset = 1'b0;
        chk_en  = 1'b1;

        // PC increment across a byte boundary, frozen by halt
        mar_write(2'b10, 8'hFF);
        i_pcLoadN = 1'b0; tick(); i_pcLoadN = 1'b1;
        check("pc load 00FF", 32'(o_pc), 32'h00FF);
        i_pcNEn = 1'b0;
        tick(); check("pc inc1", 32'(o_pc), 32'h0100);
        i_halt = 1'b1; tick(); check("pc halt", 32'(o_pc), 32'h0100);
        i_halt = 1'b0; tick(); check("pc inc2", 32'(o_pc), 32'h0101);
        i_pcNEn = 1'b1;

        // SP saturation at the top and flag clear with a simultaneous step
        i_spNEn = 1'b0; i_spUp = 1'b1;
        repeat (254) tick();
        check("sp FE", 32'(o_sp), 32'hFE);
        tick(); check("sp FF", 32'(o_sp), 32'hFF);
        check("ovf before", 32'(o_spOverflow), 32'h0);
        tick(); check("sp hold", 32'(o_sp), 32'hFF);
        check("ovf set", 32'(o_spOverflow), 32'h1);
        tick();
        i_spUp = 1'b0; i_spClrFlags = 1'b1;
        tick();
        check("sp down FE", 32'(o_sp), 32'hFE);
        check("ovf cleared", 32'(o_spOverflow), 32'h0);
        i_spNEn = 1'b1; i_spClrFlags = 1'b0;

        // Asynchronous reset in the middle of a cycle
        #1 i_reset = 1'b1;
        #1 check("async rst pc", 32'(o_pc), 32'h0);
        check("async rst sp", 32'(o_sp), 32'h0);
        tick();
        i_reset = 1'b0;

        // Underflow, then clear racing a fresh underflow
        i_spNEn = 1'b0; i_spUp = 1'b0;
        tick(); check("und set", 32'(o_spUnderflow), 32'h1);
        check("sp hold 0", 32'(o_sp), 32'h0);
        i_spClrFlags = 1'b1;
        tick(); check("und set wins", 32'(o_spUnderflow), 32'h1);
        i_spNEn = 1'b1;
        tick(); check("und cleared", 32'(o_spUnderflow), 32'h0);
        i_spClrFlags = 1'b0;
        i_spNEn = 1'b0; i_spUp = 1'b1;
        repeat (3) tick();
        i_halt = 1'b1; tick(); i_halt = 1'b0;
        repeat (2) tick();
        i_spNEn = 1'b1;
        check("sp 05", 32'(o_sp), 32'h05);

        // MAR lanes and page decode
        mar_write(2'b10, 8'h34);
        mar_write(2'b01, 8'h12);
        check("ram 11234", 32'(o_ramAddress), 32'h11234);
        mar_write(2'b01, 8'hFF);
        mar_write(2'b10, 8'h10);
        check("ram stack", 32'(o_ramAddress), 32'h00510);
        mar_write(2'b00, 8'h22);
        check("ram both lanes", 32'(o_ramAddress), 32'h12222);
        mar_write(2'b01, 8'hFE);
        check("io sel", 32'(o_ioNCE), 32'h0);
        check("ram io", 32'(o_ramAddress), 32'h1FE22);

        // Instruction register and PC load from immediate under halt
        i_romData = 24'hA51234; i_instrNWE = 1'b0;
        tick(); i_instrNWE = 1'b1;
        check("ir code", 32'(o_instrCode), 32'hA5);
        check("ir imm", 32'(o_instrImm), 32'h1234);
        i_immToAddr = 1'b1;
        #1 check("ram from imm", 32'(o_ramAddress), 32'h11234);
        i_pcLoadN = 1'b0; i_pcFromImm = 1'b1; i_halt = 1'b1; i_pcNEn = 1'b0;
        tick();
        i_pcLoadN = 1'b1; i_pcFromImm = 1'b0; i_halt = 1'b0; i_pcNEn = 1'b1;
        check("pc from imm", 32'(o_pc), 32'h1234);
        i_immToAddr = 1'b0;

        // Breakpoints: lowest index, latch, ack, slot rewrite while hit
        mar_write(2'b00, 8'h00);
        mar_write(2'b10, 8'h3D);
        i_pcLoadN = 1'b0; tick(); i_pcLoadN = 1'b1;
        bp_write(2, 16'h0040, 1'b1);
        bp_write(3, 16'h0040, 1'b1);
        bp_write(0, 16'h0040, 1'b0);
        i_pcNEn = 1'b0;
        repeat (3) tick();
        i_pcNEn = 1'b1;
        check("bp pc 40", 32'(o_pc), 32'h0040);
        check("bp hitN", 32'(o_bpHitN), 32'h0);
        check("bp idx", 32'(o_bpHitIdx), 32'h2);
        check("bp latch wait", 32'(o_bpLatched), 32'h0);
        tick(); check("bp latched", 32'(o_bpLatched), 32'h1);
        i_bpAck = 1'b1; tick(); i_bpAck = 1'b0;
        check("bp ack", 32'(o_bpLatched), 32'h0);
        tick(); check("bp no reset", 32'(o_bpLatched), 32'h0);
        bp_write(2, 16'h0040, 1'b0);
        check("bp idx after rewrite", 32'(o_bpHitIdx), 32'h3);
        check("bp no glitch latch", 32'(o_bpLatched), 32'h0);
        bp_write(3, 16'h0040, 1'b0);
        check("bp none hitN", 32'(o_bpHitN), 32'h1);
        tick();
        bp_write(3, 16'h0040, 1'b1);
        i_bpAck = 1'b1; tick(); i_bpAck = 1'b0;
        check("bp set wins ack", 32'(o_bpLatched), 32'h1);

        // PC wraps modulo 2^16
        mar_write(2'b00, 8'hFF);
        i_pcLoadN = 1'b0; tick(); i_pcLoadN = 1'b1;
        i_pcNEn = 1'b0; tick(); i_pcNEn = 1'b1;
        check("pc wrap", 32'(o_pc), 32'h0);

        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
